// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO/UART slice.
// The transmitter and the receiver both take their defaults from here.
package fifo_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BAUD_DIV   = 16;

    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_e;

    // Even parity holds when the data bits and the parity bit XOR to zero.
    function automatic logic even_parity_ok(input data_t d, input logic p);
        return ~^{d, p};
    endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Baud down-counter for the UART receiver.
// Loads half or full bit periods and flags the cycle it reaches zero.
module uart_rx_bit_timer #(
    parameter int BAUD_DIV = fifo_pkg::BAUD_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int CW = $clog2(BAUD_DIV);

    logic [CW-1:0] count;

    // Counter rests at zero once expired; the FSM ignores tick in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load_half) begin
            count <= CW'(BAUD_DIV / 2 - 1);
        end else if (load_full) begin
            count <= CW'(BAUD_DIV - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver (optional even parity) feeding the processor top.
// Presents each good byte on data with a one-cycle rx_interrupt pulse.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int BAUD_DIV   = fifo_pkg::BAUD_DIV,
    parameter bit PARITY_EN  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  rx_interrupt,
    output logic                  frame_error,
    output logic                  parity_error,
    output logic                  busy
);

    import fifo_pkg::*;

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rx_meta, rx_s, rx_d;
    uart_rx_state_e        state, state_next;
    logic                  tick, load_half, load_full;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BW-1:0]         bit_cnt;
    logic                  parity_bit;
    logic                  start_edge, last_bit, parity_ok;
    logic                  shift_en, clear_cnt, latch_parity;
    logic                  good_next, frame_err_next, parity_err_next;

    // Two-flop synchronizer plus history flop; all idle high so reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_d    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_d    <= rx_s;
        end
    end

    assign start_edge = !rx_s && rx_d;
    assign last_bit   = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign parity_ok  = !PARITY_EN || even_parity_ok(shift_reg, parity_bit);

    uart_rx_bit_timer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_bit_timer (
        .clk       (clk),
        .rst       (rst),
        .load_half (load_half),
        .load_full (load_full),
        .tick      (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_edge) state_next = START;
            START:   if (tick) state_next = rx_s ? IDLE : DATA;
            DATA:    if (tick && last_bit) state_next = PARITY_EN ? PARITY : STOP;
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_half       = (state == IDLE) && start_edge;
        load_full       = tick && (((state == START) && !rx_s) || (state == DATA) || (state == PARITY));
        clear_cnt       = (state == START) && tick;
        shift_en        = (state == DATA) && tick;
        latch_parity    = (state == PARITY) && tick;
        good_next       = (state == STOP) && tick && rx_s && parity_ok;
        parity_err_next = (state == STOP) && tick && rx_s && !parity_ok;
        frame_err_next  = (state == STOP) && tick && !rx_s;
        busy            = (state != IDLE);
    end

    // LSB arrives first, so each new bit enters at the MSB and the word slides right.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            parity_bit   <= 1'b0;
            data         <= '0;
            rx_interrupt <= 1'b0;
            frame_error  <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
                bit_cnt   <= bit_cnt + 1'b1;
            end else if (clear_cnt) begin
                bit_cnt <= '0;
            end
            if (latch_parity) parity_bit <= rx_s;
            if (good_next)    data       <= shift_reg;
            rx_interrupt <= good_next;
            frame_error  <= frame_err_next;
            parity_error <= parity_err_next;
        end
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Serial receiver feeding the processor top: samples the asynchronous UART line `rx` and reassembles 8N1 frames (optional parity).
- Each good byte is presented on `data` with a one-cycle `rx_interrupt` pulse, exactly the pair `top_processors` consumes.
- It is the receiving end of the frames the design's transmitter drives on `tx`, so a loopback `tx`->`rx` closes the link.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; must equal the width of fifo_pkg::data_t.
- BAUD_DIV, 16, clk cycles per bit; even, >= 4.
- PARITY_EN, 0, 1 = one even-parity bit between the data bits and the stop bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data  out  DATA_WIDTH (data_t)  last good byte, LSB received first.
- rx_interrupt  out  1  one-cycle pulse when `data` updates.
- frame_error  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_error  out  1  one-cycle pulse on parity mismatch; tied 0 when PARITY_EN=0.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; data=0; all pulses=0; busy=0.
  - Synchronizer flops = 1; edge-detect history flop = 1; baud counter and bit counter = 0.
  - Reset mid-frame aborts the frame silently: no pulse, `data` unchanged from its reset value 0.
- Synchronizer: 2-flop chain (`rx_s`). A history flop `rx_d` holds the previous `rx_s` for falling-edge detection.
- Total latency from a physical `rx` change to the state machine seeing it: 2 cycles.
- State machine:
  - IDLE → START when `rx_s`=0 and `rx_d`=1. Load baud counter = BAUD_DIV/2-1.
  - START: counter decrements each cycle. At 0 (mid start bit):
    - `rx_s`=0 → DATA, counter = BAUD_DIV-1, bit_cnt = 0.
    - `rx_s`=1 → IDLE (glitch rejected; no pulse).
  - DATA: at counter 0, shift `rx_s` into the MSB of the shift register (right-shift, so the LSB arrives first), increment bit_cnt, reload the counter.
    - After bit DATA_WIDTH-1 → PARITY if PARITY_EN, else STOP.
  - PARITY: at counter 0, latch the sampled bit and reload → STOP.
  - STOP: at counter 0 sample `rx_s`:
    - 1 and parity OK → `data` <= shift register, `rx_interrupt`=1 for the next cycle.
    - 1 and parity bad → `parity_error` pulse; `data` unchanged.
    - 0 → `frame_error` pulse; `data` unchanged; parity is not checked.
    - All three cases → IDLE.
- Re-arm: a new start requires a falling edge. A line held low after a frame error (break) never retriggers.
- Back-to-back frames: a start edge arriving in the cycle after STOP is accepted, so there is no dead time beyond the remaining half stop bit.
- Even parity: the XOR of the data bits and the parity bit must be 0.
- Pulses are registered, mutually exclusive, and last exactly 1 cycle.
- `data` holds its value until the next good frame. There is no overrun flag; the consumer must take `data` on the pulse.
- Timing, with the falling edge of `rx` at cycle 0 and PARITY_EN=0: `rx_interrupt` is high in cycle 3 + BAUD_DIV/2 + 9*BAUD_DIV, which is 155 for BAUD_DIV=16. Add BAUD_DIV when PARITY_EN=1.

Decomposition:
- fifo_pkg gains:
  - DATA_WIDTH constant (reused by data_t).
  - uart_rx_state_e enum {IDLE, START, DATA, PARITY, STOP}.
  - Default BAUD_DIV constant, so the transmitter and receiver share one value.
- One natural sub-module: uart_rx_bit_timer.
  - Baud down-counter with `load_half` and `load_full` inputs and a `tick` output at 0.
  - Keeps the FSM free of counter arithmetic.
- The synchronizer stays inline.

Test Plan (BAUD_DIV=16, PARITY_EN=0 unless stated):
- Reset released, `rx` held 1 for 200 cycles → busy=0, data=0, no pulses.
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first, stop=1) → rx_interrupt one cycle at cycle 155, data=0xA5, busy falls the same cycle.
- Start glitch: `rx` low for 4 cycles, then high → returns to IDLE at cycle 10, no pulse, data unchanged.
- Frame 0x3C with stop bit 0 → frame_error one cycle at 155, data keeps 0xA5; `rx` held low 500 more cycles → no further activity until `rx` rises and falls again.
- Bytes 1..8 sent back-to-back with a single stop bit each (mirrors the uart stream 1..8 fed to the processor top) → eight rx_interrupt pulses spaced 160 cycles apart, data sequence 1..8.
- PARITY_EN=1: 0x07 with parity 1 → good, pulse at 171; 0x07 with parity 0 → parity_error at 171, data unchanged. Assert rst low at cycle 80 of a frame → all outputs 0 immediately, next frame received correctly.
